// File: rtl/svf_ctrl.sv
// Sequencer and config front-end for one state-variable-filter datapath.
// Optional build macro SVF_CTRL_OVERSAMPLE_EN runs two filter passes per sample.
module svf_ctrl #(
    parameter int unsigned W       = 21,
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [W-1:0]     cfg_wdata,
    output logic             svf_rst,
    output logic             svf_in_valid,
    output logic [W-1:0]     svf_F,
    output logic [W-1:0]     svf_Q,
    output logic [W-1:0]     svf_x,
    output logic [1:0]       svf_sel,
    input  logic [W-1:0]     svf_y,
    input  logic             svf_out_valid,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             err
);

    localparam int unsigned   TW    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  Q_ONE = W'(32'h0001_0000);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [W-1:0]  f_sh;
    logic [W-1:0]  q_sh;
    logic [1:0]    mode_sh;
    logic          en_sh;
`ifdef SVF_CTRL_OVERSAMPLE_EN
    logic          second_pass;
`endif

    logic clr_c;
    logic take_c;

    // Clear beats a coincident tick; sample accept is decided from tick/state only.
    assign clr_c    = cfg_we && (cfg_addr == 2'd3) && cfg_wdata[1];
    assign take_c   = (state == S_IDLE) && tick && en_sh && !clr_c;
    assign in_ready = take_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            f_sh         <= '0;
            q_sh         <= Q_ONE;
            mode_sh      <= 2'd0;
            en_sh        <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            svf_rst      <= 1'b0;
            svf_in_valid <= 1'b0;
            svf_F        <= '0;
            svf_Q        <= Q_ONE;
            svf_x        <= '0;
            svf_sel      <= 2'd0;
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
            err          <= 1'b0;
`ifdef SVF_CTRL_OVERSAMPLE_EN
            second_pass  <= 1'b0;
`endif
        end else begin
            svf_rst      <= 1'b0;
            svf_in_valid <= 1'b0;

            // Shadow registers track CPU writes immediately.
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: f_sh    <= cfg_wdata;
                    2'd1: q_sh    <= cfg_wdata;
                    2'd2: mode_sh <= cfg_wdata[1:0];
                    2'd3: en_sh   <= cfg_wdata[0];
                endcase
            end

            if (clr_c) begin
                svf_rst      <= 1'b1;
                err          <= 1'b0;
                underrun_cnt <= '0;
                overrun_cnt  <= '0;
                out_valid    <= 1'b0;
                timer        <= '0;
                state        <= S_IDLE;
            end else begin
                if (tick && (state != S_IDLE) && (overrun_cnt != '1))
                    overrun_cnt <= overrun_cnt + 1'b1;

                case (state)
                    S_IDLE: begin
                        if (take_c) begin
                            svf_x   <= in_valid ? in_data : '0;
                            svf_F   <= f_sh;
                            svf_Q   <= q_sh;
                            svf_sel <= mode_sh;
                            if (!in_valid && (underrun_cnt != '1))
                                underrun_cnt <= underrun_cnt + 1'b1;
`ifdef SVF_CTRL_OVERSAMPLE_EN
                            second_pass <= 1'b0;
`endif
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        svf_in_valid <= 1'b1;
                        timer        <= '0;
                        state        <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (svf_out_valid) begin
`ifdef SVF_CTRL_OVERSAMPLE_EN
                            if (!second_pass) begin
                                second_pass <= 1'b1;
                                state       <= S_ISSUE;
                            end else begin
                                out_data  <= svf_y;
                                out_valid <= 1'b1;
                                state     <= S_OUTPUT;
                            end
`else
                            out_data  <= svf_y;
                            out_valid <= 1'b1;
                            state     <= S_OUTPUT;
`endif
                        end else if (timer == TW'(TIMEOUT - 1)) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_OUTPUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_svf_ctrl.sv
// Directed bench for svf_ctrl with a filter stub and an output scoreboard.
module tb_svf_ctrl;

    localparam int unsigned W     = 21;
    localparam int unsigned CNT_W = 16;
`ifdef SVF_CTRL_OVERSAMPLE_EN
    localparam int unsigned PASSES = 2;
    localparam int unsigned LAT    = 7;
`else
    localparam int unsigned PASSES = 1;
    localparam int unsigned LAT    = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [W-1:0]     cfg_wdata;
    logic             svf_rst;
    logic             svf_in_valid;
    logic [W-1:0]     svf_F;
    logic [W-1:0]     svf_Q;
    logic [W-1:0]     svf_x;
    logic [1:0]       svf_sel;
    logic [W-1:0]     svf_y;
    logic             svf_out_valid;
    logic [CNT_W-1:0] underrun_cnt;
    logic [CNT_W-1:0] overrun_cnt;
    logic             err;

    svf_ctrl #(.W(W), .TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .svf_rst(svf_rst), .svf_in_valid(svf_in_valid),
        .svf_F(svf_F), .svf_Q(svf_Q), .svf_x(svf_x), .svf_sel(svf_sel),
        .svf_y(svf_y), .svf_out_valid(svf_out_valid),
        .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Filter stub: y = x + F + step index, one cycle after each step strobe.
    logic         mute;
    logic [W-1:0] nstep;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nstep         <= '0;
            svf_y         <= '0;
            svf_out_valid <= 1'b0;
        end else if (svf_rst) begin
            nstep         <= '0;
            svf_out_valid <= 1'b0;
        end else begin
            svf_out_valid <= svf_in_valid && !mute;
            if (svf_in_valid) begin
                nstep <= nstep + 1'b1;
                svf_y <= svf_x + svf_F + nstep + 1'b1;
            end
        end
    end

    int           checks   = 0;
    int           failures = 0;
    int           rdy_cnt  = 0;
    int           siv_cnt  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_pop;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready) rdy_cnt++;
            if (svf_in_valid) siv_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got 0x%0h expected no output", out_data);
                end else begin
                    exp_pop = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(exp_pop));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [1:0] a, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic do_tick(output logic rdy);
        tick = 1'b1;
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic wait_out(input int budget, input int base, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            cyc(1);
            if (out_valid) begin
                lat = base + n;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL out_timeout: got no out_valid expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200us");
        $fatal(1);
    end

    initial begin
        int           steps;
        int           lat;
        int           r0;
        int           s0;
        logic         rdy;
        logic [W-1:0] e4;

        rst_n = 1'b0; tick = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0; mute = 1'b0;
        steps = 0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_svf_Q", 32'(svf_Q), 32'h10000);
        check("rst_svf_F", 32'(svf_F), 32'h0);
        check("rst_svf_sel", 32'(svf_sel), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_counters", 32'({underrun_cnt, overrun_cnt}), 32'h0);
        check("rst_strobes", 32'({svf_in_valid, svf_rst, in_ready}), 32'h0);

        cfg(2'd3, W'(1));

        // Nominal sample with timing.
        out_ready = 1'b1; in_valid = 1'b1; in_data = W'(32'h00100);
        steps += PASSES;
        exp_q.push_back(W'(32'h00100 + steps));
        r0 = rdy_cnt; s0 = siv_cnt;
        do_tick(rdy);
        check("t1_in_ready_on_tick", 32'(rdy), 32'h1);
        cyc(1);
        check("t1_svf_in_valid", 32'(svf_in_valid), 32'h1);
        check("t1_svf_x", 32'(svf_x), 32'h00100);
        wait_out(20, 2, lat);
        check("t1_latency", 32'(lat), 32'(LAT));
        cyc(3);
        check("t1_in_ready_pulses", 32'(rdy_cnt - r0), 32'h1);
        check("t1_step_pulses", 32'(siv_cnt - s0), 32'(PASSES));

        // F written mid-sample stays out of the running sample.
        in_data = W'(32'h00200);
        steps += PASSES;
        exp_q.push_back(W'(32'h00200 + steps));
        do_tick(rdy);
        cyc(1);
        cfg(2'd0, W'(32'h02000));
        check("t2_svf_F_mid", 32'(svf_F), 32'h0);
        wait_out(20, 0, lat);
        cyc(3);
        check("t2_svf_F_after", 32'(svf_F), 32'h0);

        // Underrun: no input sample on tick.
        in_valid = 1'b0; in_data = W'(32'h07777);
        steps += PASSES;
        exp_q.push_back(W'(32'h02000 + steps));
        r0 = rdy_cnt;
        do_tick(rdy);
        check("t3_svf_F_committed", 32'(svf_F), 32'h02000);
        check("t3_svf_x_zero", 32'(svf_x), 32'h0);
        wait_out(20, 0, lat);
        cyc(3);
        check("t3_underrun", 32'(underrun_cnt), 32'h1);

        // Backpressure with three dropped ticks.
        out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h00300);
        steps += PASSES;
        e4 = W'(32'h00300 + 32'h02000 + steps);
        exp_q.push_back(e4);
        r0 = rdy_cnt;
        do_tick(rdy);
        wait_out(20, 0, lat);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            do_tick(rdy);
        end
        cyc(2);
        check("t4_overrun", 32'(overrun_cnt), 32'h3);
        check("t4_out_valid_held", 32'(out_valid), 32'h1);
        check("t4_out_data_held", 32'(out_data), 32'(e4));
        check("t4_in_ready_pulses", 32'(rdy_cnt - r0), 32'h1);
        out_ready = 1'b1;
        cyc(1);
        check("t4_out_valid_drop", 32'(out_valid), 32'h0);
        check("t4_queue_drained", 32'(exp_q.size()), 32'h0);

        // Filter never answers: timeout sets err and returns to IDLE.
        mute = 1'b1; in_data = W'(32'h00055);
        steps += 1;
        do_tick(rdy);
        cyc(8);
        check("t5_err_before", 32'(err), 32'h0);
        cyc(1);
        check("t5_err_set", 32'(err), 32'h1);
        check("t5_no_output", 32'(out_valid), 32'h0);
        mute = 1'b0; in_data = W'(32'h00500);
        steps += PASSES;
        exp_q.push_back(W'(32'h00500 + 32'h02000 + steps));
        do_tick(rdy);
        check("t5_idle_after_timeout", 32'(rdy), 32'h1);
        wait_out(20, 0, lat);
        cyc(3);
        check("t5_err_sticky", 32'(err), 32'h1);
        cfg(2'd3, W'(3));
        steps = 0;
        check("t5_svf_rst_pulse", 32'(svf_rst), 32'h1);
        check("t5_err_cleared", 32'(err), 32'h0);
        check("t5_counters_cleared", 32'({underrun_cnt, overrun_cnt}), 32'h0);
        cyc(1);
        check("t5_svf_rst_single", 32'(svf_rst), 32'h0);

        // Clear coincident with tick drops the tick; mode commits on next sample.
        cfg(2'd2, W'(2));
        check("t6_sel_uncommitted", 32'(svf_sel), 32'h0);
        s0 = siv_cnt;
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = W'(3); tick = 1'b1;
        @(negedge clk);
        rdy = in_ready;
        cyc(1);
        cfg_we = 1'b0; tick = 1'b0;
        check("t6_clr_tick_ready", 32'(rdy), 32'h0);
        cyc(6);
        check("t6_clr_tick_no_step", 32'(siv_cnt - s0), 32'h0);
        check("t6_clr_tick_overrun", 32'(overrun_cnt), 32'h0);
        in_data = W'(32'h00400);
        steps += PASSES;
        exp_q.push_back(W'(32'h00400 + 32'h02000 + steps));
        do_tick(rdy);
        check("t6_sel_committed", 32'(svf_sel), 32'h2);
        wait_out(20, 0, lat);
        cyc(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
